// File: rtl/fir_core_out_collector.sv
// -----------------------------------------------------------------------------
// fir_core_out_collector
//
// Receiving end of the FIR core's parallel output interface. A single-cycle
// valid_core strobe captures a whole LANES-wide frame of DW-bit filter
// results. The frame is then written out one lane per beat on a ready/valid
// write port toward the DMAC writeback path, with an auto-incrementing word
// address.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   core_data   in   LANES*DW lane results, lane k at [k*DW +: DW]
//   valid_core  in   single-cycle strobe, core_data holds a complete frame
//   clr         in   synchronous clear of frame_cnt and overflow
//   base_addr   in   word address of frame 0 / lane 0, sampled at capture
//   wr_valid    out  write request valid
//   wr_ready    in   write channel accepts the current beat
//   wr_data     out  current lane result
//   wr_addr     out  word address of the current beat
//   busy        out  a frame is being drained
//   frame_done  out  one-cycle pulse after the last lane of a frame is accepted
//   overflow    out  sticky, a valid_core frame was dropped
//   frame_cnt   out  frames fully written since reset/clr (wraps)
//   fsm_state   out  debug view of the FSM (0 = IDLE, 1 = DRAIN)
//
// Write handshake: a beat transfers on a rising edge where wr_valid and
// wr_ready are both 1. Once wr_valid is raised it stays high, and wr_data /
// wr_addr stay constant, until that beat transfers; wr_valid never depends
// combinationally on wr_ready.
//
// Build option
//   COLL_DOUBLE_BUF_EN  adds a second capture buffer so a frame arriving
//                       during a drain is held as pending and drained right
//                       after the current one instead of being dropped.
// -----------------------------------------------------------------------------
module fir_core_out_collector #(
   parameter int LANES = 64,
   parameter int DW    = 24,
   parameter int AW    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LANES*DW-1:0]   core_data,
   input  logic                  valid_core,
   input  logic                  clr,
   input  logic [AW-1:0]         base_addr,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [DW-1:0]         wr_data,
   output logic [AW-1:0]         wr_addr,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overflow,
   output logic [15:0]           frame_cnt,
   output logic                  fsm_state
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [IW-1:0]       idx;
   logic [AW-1:0]       start_addr;
   logic [LANES*DW-1:0] act_buf;
   logic                beat;
   logic                last_beat;
   logic                drop;
   logic [15:0]         cnt_after;

   // Word offset of a frame relative to base_addr; the product is truncated
   // to AW bits so address arithmetic wraps modulo 2^AW.
   function automatic logic [AW-1:0] frame_offset(input logic [15:0] cnt);
      logic [AW-1:0] c;
      c = AW'(cnt);
      return c * AW'(LANES);
   endfunction

   assign beat      = wr_valid && wr_ready;
   assign last_beat = beat && (idx == LAST_IDX);

   // Frame count as it will be after this edge when the last beat lands;
   // a coincident clr takes priority over the increment.
   assign cnt_after = clr ? 16'd0 : 16'(frame_cnt + 16'd1);

`ifdef COLL_DOUBLE_BUF_EN
   logic [LANES*DW-1:0] buf_a;
   logic [LANES*DW-1:0] buf_b;
   logic                sel;       // 0: buf_a is the draining buffer
   logic                pend;      // the other buffer holds a waiting frame
   logic [AW-1:0]       pend_base; // base_addr sampled with the pending frame

   assign act_buf = sel ? buf_b : buf_a;
   // Only a third frame (one draining, one pending) is lost. A frame that
   // arrives exactly on the last beat with nothing pending is captured.
   assign drop    = (state == DRAIN) && valid_core && pend;
`else
   logic [LANES*DW-1:0] cap_buf;

   assign act_buf = cap_buf;
   assign drop    = (state == DRAIN) && valid_core;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (valid_core) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
`ifdef COLL_DOUBLE_BUF_EN
            // A pending (or just-arriving) frame continues the drain with
            // no idle cycle in between.
            if (last_beat && !(pend || valid_core)) begin
               state_nxt = IDLE;
            end
`else
            if (last_beat) begin
               state_nxt = IDLE;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr_valid = 1'b0;
      busy     = 1'b0;
      wr_data  = '0;
      wr_addr  = '0;
      if (state == DRAIN) begin
         wr_valid = 1'b1;
         busy     = 1'b1;
         wr_data  = act_buf[int'(idx)*DW +: DW];
         wr_addr  = start_addr + AW'(idx);
      end
   end

   assign fsm_state = state;

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         start_addr <= '0;
`ifdef COLL_DOUBLE_BUF_EN
         buf_a      <= '0;
         buf_b      <= '0;
         sel        <= 1'b0;
         pend       <= 1'b0;
         pend_base  <= '0;
`else
         cap_buf    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (valid_core) begin
`ifdef COLL_DOUBLE_BUF_EN
                  if (sel) begin
                     buf_b <= core_data;
                  end else begin
                     buf_a <= core_data;
                  end
`else
                  cap_buf <= core_data;
`endif
                  start_addr <= base_addr + frame_offset(frame_cnt);
                  idx        <= '0;
               end
            end
            DRAIN: begin
               if (last_beat) begin
                  idx <= '0;
`ifdef COLL_DOUBLE_BUF_EN
                  if (pend) begin
                     sel        <= ~sel;
                     pend       <= 1'b0;
                     start_addr <= pend_base + frame_offset(cnt_after);
                  end else if (valid_core) begin
                     if (sel) begin
                        buf_a <= core_data;
                     end else begin
                        buf_b <= core_data;
                     end
                     sel        <= ~sel;
                     start_addr <= base_addr + frame_offset(cnt_after);
                  end
`endif
               end else begin
                  if (beat) begin
                     idx <= idx + IW'(1);
                  end
`ifdef COLL_DOUBLE_BUF_EN
                  if (valid_core && !pend) begin
                     if (sel) begin
                        buf_a <= core_data;
                     end else begin
                        buf_b <= core_data;
                     end
                     pend      <= 1'b1;
                     pend_base <= base_addr;
                  end
`endif
               end
            end
            default: idx <= '0;
         endcase
      end
   end

   // ------------------------------------------------ status and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= last_beat;
         if (last_beat) begin
            frame_cnt <= cnt_after;
         end else if (clr) begin
            frame_cnt <= '0;
         end
         if (clr) begin
            overflow <= 1'b0;
         end else if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fir_core_out_collector.sv
// -----------------------------------------------------------------------------
// Testbench for fir_core_out_collector.
// Driver tasks issue frames; each accepted frame pushes its LANES expected
// {last, addr, data} beats into exp_q. An independent monitor pops and
// compares on every accepted beat, checks frame_done timing and checks that
// stalled beats hold their data/address.
// -----------------------------------------------------------------------------
module tb_fir_core_out_collector;

   localparam int LANES = 64;
   localparam int DW    = 24;
   localparam int AW    = 16;
   localparam int EW    = 1 + AW + DW;

   logic                clk;
   logic                rst_n;
   logic [LANES*DW-1:0] core_data;
   logic                valid_core;
   logic                clr;
   logic [AW-1:0]       base_addr;
   logic                wr_valid;
   logic                wr_ready;
   logic [DW-1:0]       wr_data;
   logic [AW-1:0]       wr_addr;
   logic                busy;
   logic                frame_done;
   logic                overflow;
   logic [15:0]         frame_cnt;
   logic                fsm_state;

   fir_core_out_collector #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_data  (core_data),
      .valid_core (valid_core),
      .clr        (clr),
      .base_addr  (base_addr),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_addr    (wr_addr),
      .busy       (busy),
      .frame_done (frame_done),
      .overflow   (overflow),
      .frame_cnt  (frame_cnt),
      .fsm_state  (fsm_state)
   );

   // ------------------------------------------------ clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------ scoreboard state
   logic [EW-1:0] exp_q[$];
   int            n_checks;
   int            n_errors;
   logic [15:0]   mdl_cnt;
   logic          mdl_ovf;
   logic [DW-1:0] lane_vals[LANES];
   logic [DW-1:0] inj_vals[LANES];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Expected beats of one frame: lane k goes to (base + cnt*LANES + k) mod 2^AW.
   task automatic push_frame(input logic [AW-1:0] base, input logic [15:0] cnt, input bit use_inj);
      logic [AW-1:0] start;
      start = AW'(32'(base) + 32'(cnt) * LANES);
      for (int k = 0; k < LANES; k++) begin
         exp_q.push_back({(k == LANES - 1), AW'(32'(start) + k),
                          use_inj ? inj_vals[k] : lane_vals[k]});
      end
   endtask

   // ------------------------------------------------ monitor
   logic          exp_done;
   logic          stalled;
   logic [DW-1:0] hold_data;
   logic [AW-1:0] hold_addr;

   initial begin
      logic [EW-1:0] e;
      exp_done = 1'b0;
      stalled  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_done = 1'b0;
            stalled  = 1'b0;
         end else begin
            chk("frame_done", 64'(frame_done), 64'(exp_done));
            exp_done = 1'b0;
            if (stalled) begin
               chk("stall_valid", 64'(wr_valid), 64'd1);
               chk("stall_data", 64'(wr_data), 64'(hold_data));
               chk("stall_addr", 64'(wr_addr), 64'(hold_addr));
            end
            stalled   = wr_valid && !wr_ready;
            hold_data = wr_data;
            hold_addr = wr_addr;
            if (wr_valid && wr_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h required no beat",
                           wr_addr, wr_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", 64'(wr_addr), 64'(e[AW+DW-1:DW]));
                  chk("wr_data", 64'(wr_data), 64'(e[DW-1:0]));
                  exp_done = e[EW-1];
               end
            end
         end
      end
   end

   // ------------------------------------------------ driver tasks
   task automatic pack_lanes(input bit use_inj);
      for (int k = 0; k < LANES; k++) begin
         core_data[k*DW +: DW] = use_inj ? inj_vals[k] : lane_vals[k];
      end
   endtask

   task automatic random_lanes();
      for (int k = 0; k < LANES; k++) begin
         lane_vals[k] = DW'($urandom);
         inj_vals[k]  = DW'($urandom);
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk) #1;
      clr     = 1'b0;
      mdl_cnt = 16'd0;
      mdl_ovf = 1'b0;
   endtask

   // Issues one frame starting at the current (post-edge) time and follows it
   // until the write port goes idle. mode 0: ready always, 1: ready toggling
   // starting low, 2: random ready. inject_at/rst_at < 0 disables the event.
   task automatic run_frame(input logic [AW-1:0] base, input int mode, input int inject_at,
                            input bit clr_last, input int rst_at, output int drain_cycles);
      int  beats;
      bit  tog;
      bit  injected;
      bit  will_beat;
      bit  clr_now;
      bit  finished;
      beats        = 0;
      tog          = 1'b0;
      injected     = 1'b0;
      finished     = 1'b0;
      drain_cycles = 0;
      pack_lanes(1'b0);
      base_addr  = base;
      valid_core = 1'b1;
      wr_ready   = 1'b1;
      push_frame(base, mdl_cnt, 1'b0);
      @(posedge clk) #1;
      valid_core = 1'b0;
      for (int k = 0; k < LANES; k++) core_data[k*DW +: DW] = DW'($urandom);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!wr_valid) begin
            finished = 1'b1;
            break;
         end
         case (mode)
            0:       wr_ready = 1'b1;
            1:       begin wr_ready = tog; tog = ~tog; end
            default: wr_ready = 1'($urandom_range(0, 1));
         endcase
         drain_cycles++;
         if (rst_at >= 0 && beats == rst_at) begin
            rst_n = 1'b0;
            exp_q.delete();
            mdl_cnt = 16'd0;
            mdl_ovf = 1'b0;
            #1;
            chk("rst_wr_valid", 64'(wr_valid), 64'd0);
            chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            @(posedge clk) #1;
            @(posedge clk) #1;
            rst_n = 1'b1;
            return;
         end
         will_beat = wr_valid && wr_ready;
         if (inject_at >= 0 && !injected && beats == inject_at) begin
            injected   = 1'b1;
            valid_core = 1'b1;
            pack_lanes(1'b1);
`ifdef COLL_DOUBLE_BUF_EN
            push_frame(base, 16'(mdl_cnt + 16'd1), 1'b1);
`else
            mdl_ovf = 1'b1;
`endif
         end
         clr_now = clr_last && will_beat && (beats % LANES == LANES - 1);
         clr     = clr_now;
         @(posedge clk) #1;
         valid_core = 1'b0;
         clr        = 1'b0;
         if (will_beat) begin
            beats++;
            if (beats % LANES == 0) mdl_cnt = 16'(mdl_cnt + 16'd1);
         end
         if (clr_now) begin
            mdl_cnt = 16'd0;
            mdl_ovf = 1'b0;
         end
      end
      if (!finished) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got busy after 3000 cycles required idle");
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(mdl_cnt));
      chk({tag, "_overflow"}, 64'(overflow), 64'(mdl_ovf));
   endtask

   // ------------------------------------------------ main sequence
   initial begin
      int cyc;
      n_checks   = 0;
      n_errors   = 0;
      mdl_cnt    = 16'd0;
      mdl_ovf    = 1'b0;
      rst_n      = 1'b0;
      core_data  = '0;
      valid_core = 1'b0;
      clr        = 1'b0;
      base_addr  = '0;
      wr_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_wr_valid", 64'(wr_valid), 64'd0);
      chk("reset_wr_data", 64'(wr_data), 64'd0);
      chk("reset_wr_addr", 64'(wr_addr), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_frame_done", 64'(frame_done), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
      chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
      rst_n = 1'b1;
      @(posedge clk) #1;

      // Incrementing lane pattern, ready always high.
      for (int k = 0; k < LANES; k++) lane_vals[k] = DW'(32'h100 + k);
      run_frame(16'h0100, 0, -1, 1'b0, -1, cyc);
      chk("t1_drain_cycles", 64'(cyc), 64'd64);
      chk("t1_frame_cnt_is_1", 64'(frame_cnt), 64'd1);
      check_status("t1");

      // Ready toggling, starting low on the first drain cycle.
      random_lanes();
      run_frame(16'h0100, 1, -1, 1'b0, -1, cyc);
      chk("t2_drain_cycles", 64'(cyc), 64'd128);
      check_status("t2");

      // Second frame offered at beat 10 of a drain.
      random_lanes();
      run_frame(16'h0100, 0, 10, 1'b0, -1, cyc);
`ifdef COLL_DOUBLE_BUF_EN
      chk("t3_drain_cycles", 64'(cyc), 64'd128);
`else
      chk("t3_drain_cycles", 64'(cyc), 64'd64);
`endif
      check_status("t3");

      // clr on the last-beat acceptance.
      random_lanes();
      run_frame(16'h0100, 2, -1, 1'b1, -1, cyc);
      check_status("t6");

      // Address wrap around 2^AW.
      random_lanes();
      run_frame(16'hFFF0, 2, -1, 1'b0, -1, cyc);
      check_status("t4");

      // Reset mid-drain, then a fresh frame starts at base + 0.
      random_lanes();
      run_frame(16'h0200, 0, -1, 1'b0, 20, cyc);
      check_status("t5_after_rst");
      random_lanes();
      run_frame(16'h0200, 2, -1, 1'b0, -1, cyc);
      check_status("t5_fresh");

      // Random frames, with an idle clr in the middle.
      for (int f = 0; f < 4; f++) begin
         random_lanes();
         if (f == 2) do_clr();
         run_frame(AW'($urandom), 2, (f == 1) ? int'($urandom_range(0, 63)) : -1,
                   1'b0, -1, cyc);
         check_status("rand");
      end

      repeat (5) @(posedge clk);
      #1;
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fir_core_out_collector.md
Name: fir_core_out_collector

Overview:
- Receiving end of the FIR core's parallel output interface.
- Captures one 64-lane frame of 24-bit filter results whenever `valid_core` pulses.
- Serializes the frame lane-by-lane onto a ready/valid memory-write port toward the DMAC writeback path, with auto-incrementing word address.
- Sits between the 64-lane 2D FIR array and the DMAC write channel.

Parameters:
- LANES, 64, number of parallel filter lanes captured per frame
- DW, 24, width of each lane result and of `wr_data`
- AW, 16, width of `base_addr` and `wr_addr`

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_data  in  LANES*DW  lane results, lane k at bits [k*DW +: DW]; lane 0 is the first output
- valid_core  in  1  single-cycle strobe: `core_data` holds a complete frame
- clr  in  1  synchronous clear of frame counter and overflow flag
- base_addr  in  AW  word address of frame 0, lane 0; sampled at capture
- wr_valid  out  1  write request valid
- wr_ready  in  1  write channel accepts the current beat
- wr_data  out  DW  current lane result
- wr_addr  out  AW  word address of current beat
- busy  out  1  a frame is being drained
- frame_done  out  1  one-cycle pulse after the last lane of a frame is accepted
- overflow  out  1  sticky: a `valid_core` frame was dropped
- frame_cnt  out  16  frames fully written since reset/clr

Behaviour:
- Reset values: `wr_valid`=0, `wr_data`=0, `wr_addr`=0, `busy`=0, `frame_done`=0, `overflow`=0, `frame_cnt`=0, FSM=IDLE, lane index=0.
- FSM has two states, IDLE and DRAIN.
- IDLE:
  - On `valid_core`=1, register all LANES words into the capture buffer.
  - In the same edge, latch the frame start address as `base_addr + frame_cnt*LANES` (mod 2^AW) and set lane index to 0.
  - Go to DRAIN.
- Latency: `valid_core` sampled at edge N gives `wr_valid`=1 with lane 0 data from cycle N+1.
- DRAIN:
  - `wr_valid`=1 and `busy`=1.
  - `wr_data` = buffer[idx]; `wr_addr` = start + idx.
  - A beat is transferred when `wr_valid` && `wr_ready`; idx then increments.
  - `wr_valid` must not drop, and `wr_data`/`wr_addr` must not change, while `wr_ready`=0.
- Last lane (idx = LANES-1) accepted:
  - Next cycle `wr_valid`=0 and `frame_done`=1 for exactly one cycle.
  - `frame_cnt` increments, wrapping 0xFFFF→0.
  - FSM returns to IDLE.
- `frame_done` and a new capture may coincide: `valid_core` in the first IDLE cycle is accepted normally.
- `valid_core` while in DRAIN (no optional feature): frame is dropped, `overflow` is set and stays set, the current drain is unaffected.
- `clr`:
  - Zeroes `frame_cnt` and `overflow` on the next edge.
  - Does not abort an in-progress drain; that frame's addresses are already latched.
  - If `clr` coincides with the last-beat acceptance, `clr` wins and `frame_cnt`=0.
- Reset asserted mid-drain: all state returns to reset values immediately; the partial frame is discarded.
- `wr_addr` arithmetic is modulo 2^AW and wraps silently.

Optional Feature:
- Macro: `COLL_DOUBLE_BUF_EN`.
- When defined:
  - Adds a second capture buffer.
  - `valid_core` during DRAIN stores the frame into the idle buffer (pending).
  - After the current frame's `frame_done`, the pending frame drains starting the next cycle, with no IDLE gap.
  - `overflow` sets only if `valid_core` arrives while one frame is draining and another is already pending.
- When undefined: single buffer, drop-and-flag behaviour as above.

Test Plan:
1. Reset, then lane k = 0x000100+k, `base_addr`=0x0100, `valid_core` pulse, `wr_ready`=1:
   - 64 consecutive beats, addresses 0x0100..0x013F, data 0x000100..0x00013F.
   - `frame_done` one cycle after beat 63; `frame_cnt`=1.
2. Second frame with `wr_ready` toggling 1/0 every cycle:
   - addresses 0x0140..0x017F; `wr_data`/`wr_addr` held stable during each stall.
   - 128 cycles of drain; `frame_cnt`=2.
3. `valid_core` at drain beat 10:
   - Without macro: `overflow`=1, still exactly 64 beats, `frame_cnt` advances by 1.
   - With macro: 128 beats back-to-back, `overflow`=0.
4. `base_addr`=0xFFF0, `frame_cnt`=0, one frame:
   - addresses 0xFFF0..0xFFFF, then 0x0000..0x002F (wrap).
5. Assert `rst_n`=0 at beat 20:
   - `wr_valid`=0 immediately, `frame_cnt`=0.
   - A fresh frame afterward starts at `base_addr`+0.
6. Assert `clr` in the same cycle as the last-beat acceptance with `overflow`=1:
   - `frame_cnt`=0, `overflow`=0, `frame_done` still pulses.
